sum_up_delta_multi: RTL and testbench
=====================================

SUM_UP_DELTA_MULTI -- requirements
Module: sum_up_delta_multi

Interface
REQ-001 SHALL have parameter NCH, default 2: number of independent channels summed (delta1, delta2, ...).
REQ-002 SHALL have parameter NLANE, default 16: lanes per channel, a power of 2, 2..64.
REQ-003 SHALL have parameter INWIDTH, default 13: unsigned lane width.
REQ-004 SHALL have parameter OUTWIDTH, default 19: unsigned sum width, at least INWIDTH+clog2(NLANE).
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid_i, input, 1: input beat valid.
REQ-008 SHALL have port in_last_i, input, 1: last beat of an accumulation frame.
REQ-009 SHALL have port acc_mode_i, input, 1: 0 = per-beat sum, 1 = frame accumulation.
REQ-010 SHALL have port data_i, input, NCH*NLANE*INWIDTH: lane l of channel c at bits [(c*NLANE+l)*INWIDTH +: INWIDTH].
REQ-011 SHALL have port lane_en_i, input, NLANE: per-lane enable mask, shared by all channels.
REQ-012 SHALL have port sum_o, output, NCH*OUTWIDTH: channel c sum at [c*OUTWIDTH +: OUTWIDTH].
REQ-013 SHALL have port sum_valid_o, output, 1: one-cycle pulse qualifying sum_o, ovf_o and beat_cnt_o.
REQ-014 SHALL have port ovf_o, output, NCH: per-channel overflow flag for the emitted sum.
REQ-015 SHALL have port beat_cnt_o, output, 16: number of beats in the emitted sum (1 in per-beat mode).

Function
REQ-016 SHALL accept one beat per cycle when in_valid_i=1, with no backpressure.
REQ-017 SHALL zero each disabled lane (lane_en_i[l]=0) before summation, in every channel.
REQ-018 SHALL sum using a registered binary adder tree of clog2(NLANE) stages after one input register stage; intermediate widths SHALL be lossless.
REQ-019 SHALL apply a final accumulate/output stage, giving fixed latency LAT = clog2(NLANE)+2 cycles from the sampling edge to sum_valid_o (LAT=6 for NLANE=16).
REQ-020 SHALL pipeline in_valid_i, in_last_i and acc_mode_i alongside the data, so each beat uses its own control values.
REQ-021 SHALL implement an accumulator FSM with states IDLE and ACC in the final stage.
REQ-022 In IDLE, a beat with acc_mode=0 SHALL emit its own sum with beat_cnt_o=1 and keep the FSM in IDLE.
REQ-023 In IDLE, a beat with acc_mode=1 and last=1 SHALL emit its own sum with beat_cnt_o=1 and keep the FSM in IDLE.
REQ-024 In IDLE, a beat with acc_mode=1 and last=0 SHALL load the accumulator, set the beat count to 1 and move the FSM to ACC.
REQ-025 In ACC, acc_mode on following beats SHALL be ignored; mode is latched only at frame start.
REQ-026 In ACC, each beat SHALL be added to the accumulator and increment the beat count.
REQ-027 In ACC, the beat with last=1 SHALL emit accumulator+beat and return the FSM to IDLE.
REQ-028 Gaps (in_valid_i=0) SHALL be allowed between beats; the FSM and accumulator SHALL hold during gaps.
REQ-029 beat_cnt_o SHALL saturate at 16'hFFFF.
REQ-030 sum_o, ovf_o and beat_cnt_o SHALL hold their last emitted values while sum_valid_o=0.
REQ-031 Overflow SHALL be evaluated per channel, per addition, in the final stage (see Configuration).

Reset
REQ-032 While rst=1: sum_o=0, sum_valid_o=0, ovf_o=0, beat_cnt_o=0, FSM=IDLE, accumulator=0, all pipeline valid bits=0.
REQ-033 Asserting rst mid-frame or with beats in flight SHALL discard them; no sum_valid_o SHALL pulse for any beat sampled before rst deasserted.
REQ-034 The first beat sampled on the edge after rst falls SHALL be processed normally.

Configuration
REQ-035 Macro SUMUP_SATURATE_EN: when defined, any accumulation exceeding 2^OUTWIDTH-1 SHALL clamp that channel to all-ones for the rest of the frame, and its ovf_o bit SHALL be 1 for that emission.
REQ-036 Without SUMUP_SATURATE_EN, sums SHALL wrap modulo 2^OUTWIDTH and ovf_o SHALL be constant 0.

Verification
REQ-037 Per-beat mode: NCH=2, NLANE=16, all lanes=100, lane_en=16'hFFFF, one beat -> after 6 cycles a single pulse, sums {1600,1600}, beat_cnt=1.
REQ-038 Mask: ch0 lane l=l, lane_en=16'h00FF -> ch0 sum=28; 16 back-to-back beats -> 16 consecutive valid pulses.
REQ-039 Frame of 3 beats (acc_mode=1, last on 3rd, 2-cycle gap after beat 1), all lanes=1 -> one pulse, sums=48, beat_cnt=3.
REQ-040 rst asserted one cycle after beat 2 of a 3-beat frame -> no pulse; a new 1-beat frame then yields its own sum only.
REQ-041 OUTWIDTH=19, all lanes=8191, 5-beat frame (5*16*8191=655280): with macro -> sum=524287, ovf=1; without -> sum=130992, ovf=0.

Source files
------------

// File: rtl/sum_up_delta_multi.sv
// Multi-channel masked lane summer: registered adder tree plus a frame accumulator.
// Optional SUMUP_SATURATE_EN clamps the accumulation and reports overflow per channel.
module sum_up_delta_multi #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned NLANE    = 16,
  parameter int unsigned INWIDTH  = 13,
  parameter int unsigned OUTWIDTH = 19
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid_i,
  input  logic                        in_last_i,
  input  logic                        acc_mode_i,
  input  logic [NCH*NLANE*INWIDTH-1:0] data_i,
  input  logic [NLANE-1:0]            lane_en_i,
  output logic [NCH*OUTWIDTH-1:0]     sum_o,
  output logic                        sum_valid_o,
  output logic [NCH-1:0]              ovf_o,
  output logic [15:0]                 beat_cnt_o
);

  localparam int unsigned LOG = $clog2(NLANE);
  localparam int unsigned TW  = INWIDTH + LOG;

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  // Heap-ordered tree: leaves at NLANE..2*NLANE-1, node n sums nodes 2n and 2n+1, root is 1.
  logic [TW-1:0]       tree_q [NCH][1:2*NLANE-1];
  logic [LOG:0]        vld_q, last_q, mode_q;

  state_e              state_q;
  logic [OUTWIDTH-1:0] acc_q     [NCH];
  logic [NCH-1:0]      acc_ovf_q;
  logic [15:0]         cnt_q;
  logic [OUTWIDTH-1:0] sum_q     [NCH];
  logic                sum_valid_q;
  logic [NCH-1:0]      ovf_q;
  logic [15:0]         beat_cnt_q;

  logic [OUTWIDTH-1:0] beat     [NCH];
  logic [OUTWIDTH-1:0] add_sum  [NCH];
  logic [NCH-1:0]      add_ovf;
  logic [15:0]         cnt_inc;
`ifdef SUMUP_SATURATE_EN
  logic [OUTWIDTH:0]   wide     [NCH];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
      mode_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        for (int n = 1; n < 2 * NLANE; n++) begin
          tree_q[c][n] <= '0;
        end
      end
    end else begin
      vld_q  <= {vld_q[LOG-1:0], in_valid_i};
      last_q <= {last_q[LOG-1:0], in_last_i};
      mode_q <= {mode_q[LOG-1:0], acc_mode_i};
      for (int c = 0; c < NCH; c++) begin
        for (int l = 0; l < NLANE; l++) begin
          tree_q[c][NLANE+l] <= lane_en_i[l] ?
                                TW'(data_i[(c*NLANE+l)*INWIDTH +: INWIDTH]) : '0;
        end
        for (int n = 1; n < NLANE; n++) begin
          tree_q[c][n] <= tree_q[c][2*n] + tree_q[c][2*n+1];
        end
      end
    end
  end

  always_comb begin
    cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    add_ovf = '0;
    for (int c = 0; c < NCH; c++) begin
      beat[c] = OUTWIDTH'(tree_q[c][1]);
`ifdef SUMUP_SATURATE_EN
      // Once clamped, all-ones stays all-ones: any further nonzero beat carries out again.
      wide[c]    = {1'b0, acc_q[c]} + {1'b0, beat[c]};
      add_ovf[c] = acc_ovf_q[c] | wide[c][OUTWIDTH];
      add_sum[c] = wide[c][OUTWIDTH] ? '1 : wide[c][OUTWIDTH-1:0];
`else
      add_ovf[c] = acc_ovf_q[c];
      add_sum[c] = acc_q[c] + beat[c];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '{default: '0};
      acc_ovf_q   <= '0;
      cnt_q       <= '0;
      sum_q       <= '{default: '0};
      sum_valid_q <= 1'b0;
      ovf_q       <= '0;
      beat_cnt_q  <= '0;
    end else begin
      sum_valid_q <= 1'b0;
      if (vld_q[LOG]) begin
        unique case (state_q)
          StIdle: begin
            if (!mode_q[LOG] || last_q[LOG]) begin
              sum_q       <= beat;
              ovf_q       <= '0;
              beat_cnt_q  <= 16'd1;
              sum_valid_q <= 1'b1;
            end else begin
              acc_q     <= beat;
              acc_ovf_q <= '0;
              cnt_q     <= 16'd1;
              state_q   <= StAcc;
            end
          end
          StAcc: begin
            if (last_q[LOG]) begin
              sum_q       <= add_sum;
              ovf_q       <= add_ovf;
              beat_cnt_q  <= cnt_inc;
              sum_valid_q <= 1'b1;
              state_q     <= StIdle;
            end else begin
              acc_q     <= add_sum;
              acc_ovf_q <= add_ovf;
              cnt_q     <= cnt_inc;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    sum_o = '0;
    for (int c = 0; c < NCH; c++) begin
      sum_o[c*OUTWIDTH +: OUTWIDTH] = sum_q[c];
    end
  end

  assign sum_valid_o = sum_valid_q;
  assign ovf_o       = ovf_q;
  assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: tb/tb_sum_up_delta_multi.sv
// Directed bench for sum_up_delta_multi: vector table plus frame, reset and overflow sequences.
module tb_sum_up_delta_multi;

  localparam int NCH   = 2;
  localparam int NLANE = 16;
  localparam int IW    = 13;
  localparam int OW    = 19;
  localparam int LAT   = 6;

`ifdef SUMUP_SATURATE_EN
  localparam int ExpOvSum  = 524287;
  localparam int ExpOvFlag = 3;
`else
  localparam int ExpOvSum  = 130992;
  localparam int ExpOvFlag = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst, in_valid, in_last, acc_mode;
  logic [NCH*NLANE*IW-1:0]   data;
  logic [NLANE-1:0]          lane_en;
  logic [NCH*OW-1:0]         sum;
  logic                      sum_valid;
  logic [NCH-1:0]            ovf;
  logic [15:0]               beat_cnt;

  sum_up_delta_multi #(
    .NCH(NCH), .NLANE(NLANE), .INWIDTH(IW), .OUTWIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_last_i(in_last),
    .acc_mode_i(acc_mode), .data_i(data), .lane_en_i(lane_en),
    .sum_o(sum), .sum_valid_o(sum_valid), .ovf_o(ovf), .beat_cnt_o(beat_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] s0;
    logic [OW-1:0] s1;
    logic [1:0]    ovf;
    logic [15:0]   cnt;
    int            cyc;
  } em_t;
  em_t emq[$];

  always @(negedge clk) begin
    if (sum_valid) emq.push_back('{sum[OW-1:0], sum[2*OW-1:OW], ovf, beat_cnt, cyc});
  end

  typedef struct {
    int          b0, s0, b1, s1;
    logic [15:0] en;
    logic        mode, last;
    int          e0, e1;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Lane l of channel c gets base + step*l.
  function automatic logic [NCH*NLANE*IW-1:0] mk(input int b0, input int s0,
                                                 input int b1, input int s1);
    logic [NCH*NLANE*IW-1:0] d;
    d = '0;
    for (int l = 0; l < NLANE; l++) begin
      d[l*IW +: IW]         = IW'(b0 + s0 * l);
      d[(NLANE+l)*IW +: IW] = IW'(b1 + s1 * l);
    end
    return d;
  endfunction

  task automatic drive(input logic [NCH*NLANE*IW-1:0] d, input logic [15:0] en,
                       input logic m, input logic l);
    @(negedge clk);
    data = d; lane_en = en; acc_mode = m; in_last = l; in_valid = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; acc_mode = 1'b0;
    end
  endtask

  task automatic chk_single(input string nm, input int e0, input int e1, input int ecnt,
                            input int eovf);
    chk({nm, "_pulses"}, emq.size(), 1);
    if (emq.size() > 0) begin
      chk({nm, "_sum0"}, emq[0].s0, e0);
      chk({nm, "_sum1"}, emq[0].s1, e1);
      chk({nm, "_cnt"}, emq[0].cnt, ecnt);
      chk({nm, "_ovf"}, emq[0].ovf, eovf);
    end
  endtask

  vec_t vt[9];
  int   t0;
  logic [NCH*NLANE*IW-1:0] d1, dm;

  initial begin
    vt[0] = '{100, 0, 100, 0, 16'hFFFF, 1'b0, 1'b0, 1600, 1600};
    vt[1] = '{0, 1, 100, 0, 16'h00FF, 1'b0, 1'b0, 28, 800};
    vt[2] = '{8191, 0, 0, 0, 16'hFFFF, 1'b0, 1'b1, 131056, 0};
    vt[3] = '{0, 1, 1, 2, 16'hFF00, 1'b0, 1'b0, 92, 192};
    vt[4] = '{100, 0, 100, 0, 16'h0000, 1'b0, 1'b0, 0, 0};
    vt[5] = '{5, 3, 7, 0, 16'h0001, 1'b0, 1'b0, 5, 7};
    vt[6] = '{5, 3, 7, 0, 16'h8000, 1'b0, 1'b0, 50, 7};
    vt[7] = '{0, 1, 100, 0, 16'hAAAA, 1'b0, 1'b0, 64, 800};
    vt[8] = '{1, 0, 1, 0, 16'hFFFF, 1'b1, 1'b1, 16, 16};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; acc_mode = 1'b0;
    data = '0; lane_en = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", sum_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt", beat_cnt, 0);

    // First beat sampled on the edge right after reset falls; checks latency too.
    @(negedge clk);
    rst = 1'b0;
    data = mk(100, 0, 100, 0); lane_en = 16'hFFFF; acc_mode = 1'b0; in_last = 1'b0;
    in_valid = 1'b1;
    t0 = cyc;
    gap(12);
    chk_single("first", 1600, 1600, 1, 0);
    if (emq.size() > 0) chk("latency", emq[0].cyc - t0, LAT);

    emq.delete();
    foreach (vt[i]) drive(mk(vt[i].b0, vt[i].s0, vt[i].b1, vt[i].s1), vt[i].en,
                          vt[i].mode, vt[i].last);
    gap(12);
    chk("table_pulses", emq.size(), 9);
    for (int i = 0; i < 9 && i < emq.size(); i++) begin
      chk($sformatf("vec%0d_sum0", i), emq[i].s0, vt[i].e0);
      chk($sformatf("vec%0d_sum1", i), emq[i].s1, vt[i].e1);
      chk($sformatf("vec%0d_cnt", i), emq[i].cnt, 1);
      chk($sformatf("vec%0d_ovf", i), emq[i].ovf, 0);
      if (i > 0) chk($sformatf("vec%0d_spacing", i), emq[i].cyc - emq[i-1].cyc, 1);
    end
    chk("hold_valid", sum_valid, 0);
    chk("hold_sum0", sum[OW-1:0], 16);
    chk("hold_cnt", beat_cnt, 1);

    emq.delete();
    repeat (16) drive(mk(0, 1, 100, 0), 16'h00FF, 1'b0, 1'b0);
    gap(12);
    chk("burst_pulses", emq.size(), 16);
    for (int i = 0; i < emq.size(); i++) begin
      chk($sformatf("burst%0d_sum0", i), emq[i].s0, 28);
      if (i > 0) chk($sformatf("burst%0d_spacing", i), emq[i].cyc - emq[i-1].cyc, 1);
    end

    // Three-beat frame with a gap; mode on beats 2 and 3 must be ignored.
    emq.delete();
    d1 = mk(1, 0, 1, 0);
    drive(d1, 16'hFFFF, 1'b1, 1'b0);
    gap(2);
    drive(d1, 16'hFFFF, 1'b0, 1'b0);
    drive(d1, 16'hFFFF, 1'b0, 1'b1);
    gap(12);
    chk_single("frame3", 48, 48, 3, 0);
    chk("frame3_hold_cnt", beat_cnt, 3);

    // Reset with frame beats still in the pipeline.
    emq.delete();
    drive(d1, 16'hFFFF, 1'b1, 1'b0);
    drive(d1, 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    gap(2);
    chk("inrst_valid", sum_valid, 0);
    chk("inrst_cnt", beat_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    data = mk(2, 0, 2, 0); lane_en = 16'hFFFF; acc_mode = 1'b1; in_last = 1'b1;
    in_valid = 1'b1;
    gap(12);
    chk_single("flush", 32, 32, 1, 0);

    // Reset while the FSM already sits in ACC.
    emq.delete();
    drive(d1, 16'hFFFF, 1'b1, 1'b0);
    gap(10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data = mk(2, 0, 2, 0); lane_en = 16'hFFFF; acc_mode = 1'b1; in_last = 1'b1;
    in_valid = 1'b1;
    gap(12);
    chk_single("accrst", 32, 32, 1, 0);

    // Five full-scale beats: 655280 exceeds 2^19-1.
    emq.delete();
    dm = mk(8191, 0, 8191, 0);
    repeat (4) drive(dm, 16'hFFFF, 1'b1, 1'b0);
    drive(dm, 16'hFFFF, 1'b1, 1'b1);
    gap(12);
    chk_single("ovf", ExpOvSum, ExpOvSum, 5, ExpOvFlag);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
